instruction_fetch_unit: RTL

Parametrised fetch stage that replaces a free-running PC register driving instruction memory directly. It owns the PC and issues word reads to a synchronous instruction memory. It buffers returned instructions with their PC in a small queue and presents them to decode over a valid/ready handshake. It accepts branch/jump redirects that flush all stale fetches.

---
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response plus the decode handshake.
// master = fetch unit, slave = memory/decode environment.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  fetchEnable;
  logic                  redirectValid;
  logic [ADDR_WIDTH-1:0] redirectTarget;
  logic                  imemReadEnable;
  logic [ADDR_WIDTH-1:0] imemAddress;
  logic [DATA_WIDTH-1:0] imemReadData;
  logic                  instrValid;
  logic                  instrReady;
  logic [DATA_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0] instrPC;
  logic                  misalignError;

  modport master (
    input  fetchEnable, redirectValid, redirectTarget, imemReadData, instrReady,
    output imemReadEnable, imemAddress, instrValid, instruction, instrPC, misalignError
  );

  modport slave (
    output fetchEnable, redirectValid, redirectTarget, imemReadData, instrReady,
    input  imemReadEnable, imemAddress, instrValid, instruction, instrPC, misalignError
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one-cycle-latency word reads, queues (pc, instr) for decode.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirects are ignored and flag misalignError.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    QUEUE_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input logic                  clock,
  input logic                  reset,
  instruction_fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, STALL} fetchStateT;

  fetchStateT            state, lastState;
  logic [ADDR_WIDTH-1:0] pc, reqPC, redirectPC;
  logic [PTR_W-1:0]      rdPtr, wrPtr;
  logic [CNT_W-1:0]      count;
  logic [SUM_W-1:0]      used, limit;
  logic                  inflight, pop, push, credit, redirectTaken;

  logic [DATA_WIDTH-1:0] dataMem [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pcMem   [QUEUE_DEPTH];

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalignFlag;
  assign redirectTaken = bus.redirectValid && (bus.redirectTarget[1:0] == 2'b00);
  assign redirectPC    = bus.redirectTarget;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                          misalignFlag <= 1'b0;
    else if (bus.redirectValid && !redirectTaken)       misalignFlag <= 1'b1;
  end
  assign bus.misalignError = misalignFlag;
`else
  assign redirectTaken     = bus.redirectValid;
  assign redirectPC        = bus.redirectTarget & ~ADDR_WIDTH'(3);
  assign bus.misalignError = 1'b0;
`endif

  // A RUN cycle always leaves exactly one response arriving next cycle.
  assign inflight = (lastState == RUN);

  assign bus.instrValid  = (count != '0);
  assign bus.instruction = bus.instrValid ? dataMem[rdPtr] : '0;
  assign bus.instrPC     = bus.instrValid ? pcMem[rdPtr]   : '0;

  assign pop  = bus.instrValid && bus.instrReady;
  assign push = inflight && !redirectTaken;

  // A pop frees its slot in the same cycle, so it raises the limit rather than lowering usage.
  assign used   = SUM_W'(count) + SUM_W'(inflight);
  assign limit  = SUM_W'(QUEUE_DEPTH) + SUM_W'(pop);
  assign credit = used < limit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state           = IDLE;
    bus.imemAddress = pc;
    if (reset) begin
      state = IDLE;
    end else if (bus.fetchEnable) begin
      if (redirectTaken) begin
        // The queue is being flushed, so the target fetch needs no credit.
        state           = RUN;
        bus.imemAddress = redirectPC;
      end else if (credit) begin
        state = RUN;
      end else begin
        state = STALL;
      end
    end
  end

  assign bus.imemReadEnable = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lastState <= IDLE;
      pc        <= RESET_PC;
      reqPC     <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
    end else begin
      lastState <= state;
      if (state == RUN) begin
        pc    <= bus.imemAddress + ADDR_WIDTH'(4);
        reqPC <= bus.imemAddress;
      end else if (redirectTaken) begin
        pc <= redirectPC;
      end

      if (redirectTaken) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PTR_W'(1);
        if (pop)  rdPtr <= rdPtr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: queue storage is not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clock) begin
    if (push) begin
      dataMem[wrPtr] <= bus.imemReadData;
      pcMem[wrPtr]   <= reqPC;
    end
  end
endmodule
